proc_phase_sequencer: RTL

//  Sits directly downstream of the divide-by-4 clock divider. Samples its divided output (div_clk) in the

---
 rtl/proc_phase_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/proc_phase_sequencer.sv
// ---------------------------------------------------------------------------
// proc_phase_sequencer
//
// Purpose:
//   Sits downstream of the divide-by-4 clock divider. Samples div_clk in the
//   fast clk domain and turns each div_clk period into four one-hot pipeline
//   strobes (fetch/exec/mem/wb), one per fast cycle. Provides run/step/halt
//   control, a retired-cycle counter, and supervises divider health: bad
//   edge spacing or a stalled div_clk raises a sticky error and halts.
//
// Ports:
//   clk          in   fast clock, everything on its rising edge
//   reset        in   synchronous, active-high; clears all state
//   div_clk      in   divider output
//   run          in   level: issue processor cycles continuously
//   step         in   pulse: issue exactly one processor cycle (IDLE only)
//   halt_req     in   finish the in-flight cycle, then HALTED
//   fetch_en     out  strobe at rise+1
//   exec_en      out  strobe at rise+2
//   mem_en       out  strobe at fall+1
//   wb_en        out  strobe at fall+2
//   busy         out  waiting for / running cycles, or a cycle in flight
//   halted       out  controller is HALTED
//   sync_err     out  sticky divider fault
//   cycle_count  out  number of wb_en strobes, wraps
// ---------------------------------------------------------------------------
module proc_phase_sequencer #(
  parameter int HALF_PERIOD = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  output logic             fetch_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic             sync_err,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int            SW = $clog2(HALF_PERIOD + 1);
  localparam logic [SW-1:0] HP = SW'(HALF_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_ACTIVE,
    S_HALTED
  } state_t;

  state_t        r_state;
  logic          r_single;
  logic          r_halt_pend;
  logic          r_d_q;
  logic          r_cyc_act;
  logic          r_armed;
  logic [SW-1:0] r_since;     // fast cycles since the last div_clk edge

  state_t w_state_nxt;
  logic   w_single_nxt;
  logic   w_halt_pend_nxt;
  logic   w_cyc_act_nxt;
  logic   w_rise;
  logic   w_fall;
  logic   w_edge;
  logic   w_err_det;
  logic   w_fault;
  logic   w_halt_now;
  logic   w_accept;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_rise     = div_clk & ~r_d_q;
    w_fall     = ~div_clk & r_d_q;
    w_edge     = w_rise | w_fall;
    // Once armed, every edge must land exactly HALF_PERIOD cycles after the
    // previous one: an early edge or a missing one is a divider fault.
    w_err_det  = r_armed & (w_edge ? (r_since != HP) : (r_since == HP));
    w_fault    = sync_err | w_err_det;
    w_halt_now = r_halt_pend | halt_req;

    w_state_nxt     = r_state;
    w_single_nxt    = r_single;
    w_halt_pend_nxt = r_halt_pend;
    w_accept        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (halt_req) begin
          w_state_nxt = S_HALTED;
        end else if (run) begin
          w_state_nxt  = S_WAIT_RISE;
          w_single_nxt = 1'b0;
        end else if (step) begin
          w_state_nxt  = S_WAIT_RISE;
          w_single_nxt = 1'b1;
        end
      end
      S_WAIT_RISE: begin
        w_halt_pend_nxt = w_halt_now;
        if (w_halt_now) begin
          if (!r_cyc_act) w_state_nxt = S_HALTED;
        end else if (w_rise) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        w_halt_pend_nxt = w_halt_now;
        if (w_rise) begin
          if (run && !r_single && !w_halt_now) w_accept = 1'b1;
          else w_state_nxt = w_halt_now ? S_HALTED : S_IDLE;
        end
      end
      default: ;  // HALTED is left only through reset
    endcase

    // A divider fault overrides everything and kills the in-flight cycle.
    if (w_fault) begin
      w_state_nxt = S_HALTED;
      w_accept    = 1'b0;
    end

    // The cycle stays in flight from the accepted rise until wb_en is issued.
    w_cyc_act_nxt = ~w_fault & (w_accept | (r_cyc_act & ~mem_en));
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_single    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_d_q       <= 1'b0;
      r_cyc_act   <= 1'b0;
      r_armed     <= 1'b0;
      r_since     <= '0;
      fetch_en    <= 1'b0;
      exec_en     <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      sync_err    <= 1'b0;
      cycle_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_single    <= w_single_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      r_d_q       <= div_clk;
      r_cyc_act   <= w_cyc_act_nxt;
      r_armed     <= r_armed | w_edge;

      // Saturates at HALF_PERIOD; reaching it without an edge is the stall.
      if (w_edge)             r_since <= SW'(1);
      else if (r_since != HP) r_since <= r_since + SW'(1);

      fetch_en <= w_accept;
      exec_en  <= fetch_en & r_cyc_act & ~w_fault;
      mem_en   <= w_fall & r_cyc_act & ~w_fault;
      wb_en    <= mem_en & r_cyc_act & ~w_fault;

      busy     <= (w_state_nxt == S_WAIT_RISE) | (w_state_nxt == S_ACTIVE) | w_cyc_act_nxt;
      halted   <= (w_state_nxt == S_HALTED);
      sync_err <= w_fault;

      if (wb_en) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule
